// File: rtl/instr_dispatch.sv
// Fetches one program pass per sample_tick and issues each instruction to its branch once its channels are free.
// Issue is a registered valid/ready handshake that holds until accepted; a tick mid-pass restarts the pass after that.

`ifndef N_INSTR_BRANCHES
`define N_INSTR_BRANCHES 4
`endif
`ifndef INSTR_BRANCH_MAC
`define INSTR_BRANCH_MAC 2
`endif

module instr_dispatch #(
    parameter int data_width   = 16,
    parameter int max_inflight = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         sample_tick,
    input  logic [7:0]                   prog_len,
    output logic [7:0]                   prog_addr,
    input  logic [31:0]                  prog_data,
    output logic [`N_INSTR_BRANCHES-1:0] out_valid,
    input  logic [`N_INSTR_BRANCHES-1:0] out_ready,
    output logic [31:0]                  out_instr,
    output logic [8:0]                   out_commit_id,
    input  logic                         commit_pulse,
    input  logic                         commit_wr_en,
    input  logic [3:0]                   commit_wr_addr,
    output logic                         busy,
    output logic                         overrun
);

    localparam int            NB       = `N_INSTR_BRANCHES;
    localparam logic [3:0]    BR_MAC   = 4'(`INSTR_BRANCH_MAC);
    localparam logic [7:0]    MAX_INFL = 8'(max_inflight);
    localparam logic [NB-1:0] VLD_ONE  = NB'(1);

    if (max_inflight < 1 || max_inflight > 255 || data_width < 1) begin : g_bad_params
        $error("instr_dispatch: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, DONE} state_t;

    state_t      state;
    logic [7:0]  pc;
    logic [7:0]  len;
    logic [7:0]  len_pend;
    logic        restart_pend;
    logic [31:0] instr;
    logic [8:0]  commit_id;
    logic [7:0]  inflight;
    logic [7:0]  inflight_next;
    logic [15:0] sb;
    logic [15:0] sb_next;

    logic        hs;
    logic        abort;
    logic        do_restart;
    logic        cand_nop;
    logic        cand_elig;
    logic [31:0] cand;
    logic [7:0]  restart_len;
    logic [7:0]  pc_inc;

    assign busy = (state == FETCH) || (state == WAIT) || (state == ISSUE);

    always_comb begin
        hs = enable && (state == ISSUE) && (|(out_valid & out_ready));

        // A set from this cycle's issue overrides a clear of the same channel.
        sb_next = sb;
        if (commit_wr_en)
            sb_next[commit_wr_addr] = 1'b0;
        if (hs && (instr[31:28] != BR_MAC))
            sb_next[instr[27:24]] = 1'b1;

        inflight_next = inflight;
        if (hs && !(commit_pulse && (inflight != 8'd0)))
            inflight_next = inflight + 8'd1;
        else if (!hs && commit_pulse && (inflight != 8'd0))
            inflight_next = inflight - 8'd1;

        // Eligibility looks at next-cycle bookkeeping so out_valid can be a register
        // without costing a cycle: WAIT judges the word arriving from memory.
        cand      = (state == WAIT) ? prog_data : instr;
        cand_nop  = 32'(cand[31:28]) >= 32'(NB);
        cand_elig = !cand_nop
                    && !sb_next[cand[23:20]]
                    && !sb_next[cand[19:16]]
                    && ((cand[31:28] == BR_MAC) || !sb_next[cand[27:24]])
                    && (inflight_next < MAX_INFL);

        abort       = restart_pend || (sample_tick && busy);
        do_restart  = enable && busy && abort && !((|out_valid) && !hs);
        restart_len = sample_tick ? prog_len : len_pend;
        pc_inc      = pc + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= 8'd0;
            len           <= 8'd0;
            len_pend      <= 8'd0;
            restart_pend  <= 1'b0;
            instr         <= 32'd0;
            commit_id     <= 9'd0;
            inflight      <= 8'd0;
            sb            <= 16'd0;
            prog_addr     <= 8'd0;
            out_valid     <= '0;
            out_instr     <= 32'd0;
            out_commit_id <= 9'd0;
            overrun       <= 1'b0;
        end else begin
            // Commit bookkeeping keeps running while disabled so no retirement is lost.
            sb       <= sb_next;
            inflight <= inflight_next;

            if (enable) begin
                if (sample_tick && busy) begin
                    overrun      <= 1'b1;
                    len_pend     <= prog_len;
                    restart_pend <= 1'b1;
                end

                if (hs) begin
                    out_valid <= '0;
                    commit_id <= commit_id + 9'd1;
                end

                case (state)
                    IDLE, DONE: begin
                        if (sample_tick) begin
                            pc        <= 8'd0;
                            prog_addr <= 8'd0;
                            len       <= prog_len;
                            state     <= (prog_len == 8'd0) ? DONE : FETCH;
                        end
                    end
                    FETCH: begin
                        state <= WAIT;
                    end
                    WAIT: begin
                        instr <= prog_data;
                        state <= ISSUE;
                        if (cand_elig && !abort) begin
                            out_valid     <= VLD_ONE << prog_data[31:28];
                            out_instr     <= prog_data;
                            out_commit_id <= commit_id;
                        end
                    end
                    ISSUE: begin
                        if (hs || (cand_nop && (out_valid == '0))) begin
                            pc        <= pc_inc;
                            prog_addr <= pc_inc;
                            state     <= (pc_inc == len) ? DONE : FETCH;
                        end else if ((out_valid == '0) && cand_elig && !abort) begin
                            out_valid     <= VLD_ONE << instr[31:28];
                            out_instr     <= instr;
                            out_commit_id <= commit_id;
                        end
                    end
                    default: state <= IDLE;
                endcase

                // Abandon the pass once nothing is left waiting on a handshake.
                if (do_restart) begin
                    pc           <= 8'd0;
                    prog_addr    <= 8'd0;
                    len          <= restart_len;
                    restart_pend <= 1'b0;
                    state        <= (restart_len == 8'd0) ? DONE : FETCH;
                end
            end
        end
    end

endmodule

// File: doc/instr_dispatch.md
INSTR_DISPATCH -- requirements
Module: instr_dispatch

Interface
REQ-001 Parameter: data_width, default 16, sample width; carried only for consistency with the core, no datapath use.
REQ-002 Parameter: max_inflight, default 16, range 1..255, maximum issued-but-uncommitted instructions.
REQ-003 Port: clk  in  1  sole clock; all logic on posedge.
REQ-004 Port: reset  in  1  synchronous, active-high.
REQ-005 Port: enable  in  1  when low: no fetch, no issue, no state change; pending out_valid held.
REQ-006 Port: sample_tick  in  1  one-cycle pulse starting one program pass.
REQ-007 Port: prog_len  in  8  instruction count per pass; sampled at pass start.
REQ-008 Port: prog_addr  out  8  program memory read address.
REQ-009 Port: prog_data  in  32  instruction word, valid exactly 1 cycle after prog_addr.
REQ-010 Port: out_valid  out  `N_INSTR_BRANCHES  one-hot issue request per branch.
REQ-011 Port: out_ready  in  `N_INSTR_BRANCHES  branch accept.
REQ-012 Port: out_instr  out  32  issued instruction, broadcast to all branches.
REQ-013 Port: out_commit_id  out  9  sequence tag of issued instruction.
REQ-014 Port: commit_pulse  in  1  one commit retired this cycle (OR of commit-stage accepts).
REQ-015 Port: commit_wr_en  in  1  channel write from commit stage.
REQ-016 Port: commit_wr_addr  in  4  channel written.
REQ-017 Port: busy  out  1  high in any state except IDLE/DONE.
REQ-018 Port: overrun  out  1  sticky: sample_tick arrived while busy.

Function
REQ-019 Instruction fields: branch = [31:28], dest = [27:24], src_a = [23:20], src_b = [19:16].
REQ-020 branch >= `N_INSTR_BRANCHES: NOP; skipped, no commit_id consumed.
REQ-021 States: IDLE, FETCH (drive prog_addr=pc), WAIT (memory latency), ISSUE, DONE.
REQ-022 IDLE/DONE + enable + sample_tick -> pc=0, latch prog_len; prog_len=0 -> DONE, else FETCH.
REQ-023 FETCH -> WAIT -> ISSUE, 1 cycle each; prog_data captured at end of WAIT.
REQ-024 Issue stalls (out_valid low) when any of: dest, src_a or src_b pending in scoreboard; inflight == max_inflight.
REQ-025 Branch INSTR_BRANCH_MAC does not write a channel: its dest is not checked or marked; sources still checked.
REQ-026 Issue: out_valid[branch]=1, out_instr, out_commit_id held stable until out_ready[branch]; no retraction.
REQ-027 Handshake cycle (valid&ready): commit_id+1 (wraps 511->0), inflight+1, dest bit set (non-MAC), pc+1; pc==len -> DONE, else FETCH.
REQ-028 Throughput: at most one issue per 3 cycles with no stall.
REQ-029 commit_pulse decrements inflight; simultaneous issue and commit_pulse leaves inflight unchanged.
REQ-030 commit_wr_en clears scoreboard bit commit_wr_addr; same-cycle set and clear of one bit -> set wins.
REQ-031 Channel 0 is the sample input channel; the sample_tick write carries no scoreboard effect.
REQ-032 sample_tick while busy: overrun=1; remainder of pass abandoned after any pending handshake completes; restart at pc=0; commit_id, inflight, scoreboard preserved.
REQ-033 commit_pulse with inflight=0: ignored, no underflow.

Reset
REQ-034 On reset: state IDLE, pc=0, prog_addr=0, out_valid=0, out_instr=0, out_commit_id=0, inflight=0, scoreboard=0, busy=0, overrun=0.
REQ-035 reset mid-pass overrides all; next commit_id issued is 0.

Verification
REQ-036 prog_len=3, independent ALU instrs, ready tied high, commits returned -> ids 0,1,2 issued; DONE, busy=0.
REQ-037 instr0 dest=5, instr1 src_a=5 -> instr1 held (valid low) until commit_wr_en addr=5, issued next eligible cycle.
REQ-038 max_inflight=2, no commit_pulse, 4 instrs -> exactly 2 issued; third issues 1 cycle after commit_pulse.
REQ-039 branch field = 0xF -> skipped, next valid instr gets contiguous id; 512 issues -> id wraps 511->0.
REQ-040 sample_tick at pc=2 of 5 with out_ready low -> overrun=1, out_valid held until ready, then pc restarts at 0.
REQ-041 reset asserted while out_valid high -> next cycle all outputs 0, state IDLE.
